// File: rtl/tweet_uart_tx_pkg.sv
// Shared constants, FSM encoding and line-level helper for the tweetboard UART
// transmit path. The receive path uses the same baud and data-width constants.
package tweet_uart_tx_pkg;

    localparam int CLKS_PER_BIT_9600 = 5208;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Line level that a given FSM state drives onto serialOut.
    function automatic logic frame_line(tx_state_t s, logic data_bit);
        case (s)
            START:   return 1'b0;
            DATA:    return data_bit;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/tweet_uart_tx_if.sv
// Byte write port from the tweet store into the UART transmit queue.
interface tweet_uart_tx_if;
    import tweet_uart_tx_pkg::*;

    logic [UART_DATA_BITS-1:0] wr_data;
    logic                      wr_valid;
    logic                      wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/tweet_byte_fifo.sv
// Synchronous byte FIFO with push/pop on the same edge; DEPTH is a power of
// two so the pointers wrap by natural overflow.
module tweet_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 5'(DEPTH));
    assign empty   = (count == 5'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone say which entries are valid.
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tweet_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop
// serialiser with a registered line output.
module tweet_uart_tx
    import tweet_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                  sysclk,
    input  logic                  reset,
    tweet_uart_tx_if.slave        wr,
    output logic                  serialOut,
    output logic                  busy,
    output logic [4:0]            fifo_count
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state, state_next;
    logic [15:0]               baud_cnt, baud_next;
    logic [2:0]                bit_cnt, bit_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next;
    logic                      bit_tick;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_head;

    tweet_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (wr.wr_valid),
        .push_data (wr.wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr.wr_ready = !fifo_full;
    assign busy        = (state != IDLE) || (fifo_count != 5'd0);
    assign bit_tick    = (baud_cnt == BAUD_LAST);

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        fifo_pop   = 1'b0;

        if (state != IDLE) begin
            baud_next = bit_tick ? 16'd0 : baud_cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
                    bit_next   = 3'd0;
                    baud_next  = 16'd0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = {1'b0, shift[UART_DATA_BITS-1:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT) state_next = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (bit_tick) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_head;
                        bit_next   = 3'd0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The line register follows the next state so it changes on the same edge as the FSM.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shift     <= '0;
            serialOut <= 1'b1;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift     <= shift_next;
            serialOut <= frame_line(state_next, shift_next[0]);
        end
    end

endmodule

// File: tb/tb_tweet_uart_tx.sv
// Scoreboard bench for tweet_uart_tx: a default-rate and a fast-rate instance,
// with a line monitor that decodes frames and checks them against queued bytes.
module tb_tweet_uart_tx;
    import tweet_uart_tx_pkg::*;

    localparam int SLOW_CPB = CLKS_PER_BIT_9600;
    localparam int FAST_CPB = 16;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic       reset;
    logic       slow_line, fast_line, slow_busy, fast_busy;
    logic [4:0] slow_count, fast_count;

    tweet_uart_tx_if slow_if ();
    tweet_uart_tx_if fast_if ();

    tweet_uart_tx #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(8)) dut_slow (
        .sysclk     (sysclk),
        .reset      (reset),
        .wr         (slow_if),
        .serialOut  (slow_line),
        .busy       (slow_busy),
        .fifo_count (slow_count)
    );

    tweet_uart_tx #(.CLKS_PER_BIT(FAST_CPB), .FIFO_DEPTH(8)) dut_fast (
        .sysclk     (sysclk),
        .reset      (reset),
        .wr         (fast_if),
        .serialOut  (fast_line),
        .busy       (fast_busy),
        .fifo_count (fast_count)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         use_fast = 1'b0;
    int         mon_cpb  = SLOW_CPB;
    bit         mon_abort = 1'b1;
    logic [7:0] exp_q [$];
    int         start_times [$];
    int         frames_done = 0;
    int         cyc = 0;
    logic       mon_line;
    logic       mon_busy;
    logic [4:0] mon_count;

    assign mon_line  = use_fast ? fast_line  : slow_line;
    assign mon_busy  = use_fast ? fast_busy  : slow_busy;
    assign mon_count = use_fast ? fast_count : slow_count;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic offer(input logic [7:0] d);
        if (use_fast) begin
            fast_if.wr_data  = d;
            fast_if.wr_valid = 1'b1;
        end else begin
            slow_if.wr_data  = d;
            slow_if.wr_valid = 1'b1;
        end
    endtask

    task automatic release_wr();
        fast_if.wr_valid = 1'b0;
        slow_if.wr_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(frames_done >= target), 1);
    endtask

    // Monitor: samples the selected line on every falling clock edge, checks that
    // each bit slot is constant for exactly mon_cpb cycles and decodes mid-bit.
    initial begin : monitor
        bit         in_frame;
        bit         frame_bad;
        int         pos;
        int         slot;
        int         off;
        logic       slot_val;
        logic [7:0] rx_byte;
        in_frame  = 1'b0;
        frame_bad = 1'b0;
        pos       = 0;
        slot_val  = 1'b1;
        rx_byte   = '0;
        forever begin
            @(negedge sysclk);
            cyc++;
            if (mon_abort) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && mon_line == 1'b0) begin
                    in_frame  = 1'b1;
                    frame_bad = 1'b0;
                    pos       = 0;
                    start_times.push_back(cyc);
                end
                if (in_frame) begin
                    slot = pos / mon_cpb;
                    off  = pos % mon_cpb;
                    if (off == 0) slot_val = mon_line;
                    else if (mon_line !== slot_val) frame_bad = 1'b1;
                    if (slot == 0 && mon_line !== 1'b0) frame_bad = 1'b1;
                    if (slot == 9 && mon_line !== 1'b1) frame_bad = 1'b1;
                    if (slot >= 1 && slot <= 8 && off == mon_cpb / 2) rx_byte[3'(slot - 1)] = mon_line;
                    pos++;
                    if (pos == 10 * mon_cpb) begin
                        in_frame = 1'b0;
                        frames_done++;
                        check("frame_shape", int'(frame_bad), 0);
                        check("frame_expected", int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) check("rx_byte", int'(rx_byte), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int         c0;
        int         f0;
        int         bad;
        logic [7:0] burst [3];

        reset = 1'b0;
        release_wr();
        slow_if.wr_data = '0;
        fast_if.wr_data = '0;

        // Reset values and a long quiet idle afterwards.
        repeat (10) tick();
        check("rst_slow_line",  int'(slow_line), 1);
        check("rst_slow_busy",  int'(slow_busy), 0);
        check("rst_slow_count", int'(slow_count), 0);
        check("rst_slow_ready", int'(slow_if.wr_ready), 1);
        check("rst_fast_line",  int'(fast_line), 1);
        check("rst_fast_count", int'(fast_count), 0);
        check("rst_fast_ready", int'(fast_if.wr_ready), 1);
        reset     = 1'b1;
        mon_abort = 1'b0;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (slow_line !== 1'b1 || slow_busy !== 1'b0 || slow_count !== 5'd0) bad++;
            if (fast_line !== 1'b1 || fast_busy !== 1'b0 || fast_count !== 5'd0) bad++;
        end
        check("idle_after_reset", bad, 0);
        check("idle_no_frames", frames_done, 0);

        // Single 0x55 at the default rate.
        start_times.delete();
        exp_q.push_back(8'h55);
        c0 = cyc;
        offer(8'h55);
        tick();
        release_wr();
        check("single_count_after_write", int'(slow_count), 1);
        check("single_line_before_pop", int'(slow_line), 1);
        tick();
        check("single_start_low", int'(slow_line), 0);
        check("single_count_after_pop", int'(slow_count), 0);
        check("single_busy", int'(slow_busy), 1);
        wait_frames(1, 11 * SLOW_CPB, "single_frame_done");
        check("single_start_latency", start_times.size() > 0 ? start_times[0] - c0 : -1, 2);
        check("single_busy_last_stop", int'(slow_busy), 1);
        tick();
        check("single_busy_dropped", int'(slow_busy), 0);

        // Back-to-back burst at the fast rate.
        use_fast = 1'b1;
        mon_cpb  = FAST_CPB;
        start_times.delete();
        f0 = frames_done;
        burst[0] = 8'h2A;
        burst[1] = 8'h08;
        burst[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(burst[i]);
            offer(burst[i]);
            tick();
            check("burst_count", int'(fast_count), (i == 2) ? 2 : 1);
        end
        release_wr();
        wait_frames(f0 + 1, 11 * FAST_CPB, "burst_frame1");
        check("burst_count_end_frame1", int'(fast_count), 2);
        tick();
        check("burst_count_after_pop", int'(fast_count), 1);
        wait_frames(f0 + 3, 25 * FAST_CPB, "burst_frames_done");
        check("burst_gap_12", start_times.size() == 3 ? start_times[1] - start_times[0] : -1, 10 * FAST_CPB);
        check("burst_gap_23", start_times.size() == 3 ? start_times[2] - start_times[1] : -1, 10 * FAST_CPB);
        tick();
        check("burst_busy_dropped", int'(mon_busy), 0);

        // Overflow: ten offers with valid held; the tenth finds the FIFO full.
        f0 = frames_done;
        for (int k = 0; k < 10; k++) begin
            offer(8'(k));
            check("ovf_ready", int'(fast_if.wr_ready), (k < 9) ? 1 : 0);
            if (k < 9) exp_q.push_back(8'(k));
            tick();
        end
        release_wr();
        check("ovf_count_full", int'(fast_count), 8);
        wait_frames(f0 + 9, 95 * FAST_CPB, "ovf_frames_done");
        tick();
        check("ovf_busy_dropped", int'(mon_busy), 0);
        check("ovf_queue_drained", exp_q.size(), 0);

        // Reset in the middle of bit 3 of 0xA5 with two more bytes queued.
        f0 = frames_done;
        offer(8'hA5);
        tick();
        offer(8'h11);
        tick();
        offer(8'h22);
        tick();
        release_wr();
        repeat (4 * FAST_CPB + FAST_CPB / 2 - 1) tick();
        check("abort_line_bit3", int'(fast_line), 0);
        check("abort_count_before", int'(fast_count), 2);
        mon_abort = 1'b1;
        reset     = 1'b0;
        tick();
        check("abort_line_high", int'(fast_line), 1);
        check("abort_count_cleared", int'(fast_count), 0);
        check("abort_busy", int'(fast_busy), 0);
        tick();
        reset     = 1'b1;
        mon_abort = 1'b0;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (fast_line !== 1'b1 || fast_busy !== 1'b0 || fast_count !== 5'd0) bad++;
        end
        check("abort_quiet_after", bad, 0);
        check("abort_no_frames", frames_done, f0);

        // Loopback capture of a short message.
        f0 = frames_done;
        burst[0] = 8'h2A;
        burst[1] = 8'h2A;
        burst[2] = 8'h08;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(burst[i]);
            offer(burst[i]);
            tick();
        end
        release_wr();
        wait_frames(f0 + 3, 35 * FAST_CPB, "loop_frames_done");
        tick();
        check("loop_queue_drained", exp_q.size(), 0);
        check("loop_count_empty", int'(mon_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
